scoreboard: RTL and testbench

- Register-hazard controller that sequences the operand-forwarding datapath in the integer pipeline.
- Tracks destination registers of in-flight multi-cycle ops (load, mul/div) in a pending vector.
- Stalls issue on unresolved RAW/WAW hazards.
- Drives per-operand source selects for the forwarding mux: register file, execute result, or long-op completion.

---
 rtl/scoreboard_pkg.sv | 33 +++
 rtl/scoreboard_if.sv | 37 +++
 rtl/scoreboard_operand.sv | 33 +++
 rtl/scoreboard.sv | 113 +++++++++++
 tb/tb_scoreboard.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the register-hazard scoreboard.
package scoreboard_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_CMP = 2'b10;

  typedef struct packed {
    logic              issue_valid;
    logic              issue_rden1;
    logic [REG_AW-1:0] issue_raddr1;
    logic              issue_rden2;
    logic [REG_AW-1:0] issue_raddr2;
    logic              issue_wren;
    logic [REG_AW-1:0] issue_waddr;
    logic              issue_long;
    logic              execute_wren;
    logic [REG_AW-1:0] execute_waddr;
    logic              complete_valid;
    logic [REG_AW-1:0] complete_waddr;
    logic              flush;
  } scoreboard_in_type;

  typedef struct packed {
    logic       stall;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;
    logic       busy;
  } scoreboard_out_type;

endpackage

// File: rtl/scoreboard_if.sv
// Decode/execute/writeback view of the scoreboard; master is the pipeline side.
interface scoreboard_if;
  import scoreboard_pkg::*;

  logic              issue_valid;
  logic              issue_rden1;
  logic [REG_AW-1:0] issue_raddr1;
  logic              issue_rden2;
  logic [REG_AW-1:0] issue_raddr2;
  logic              issue_wren;
  logic [REG_AW-1:0] issue_waddr;
  logic              issue_long;
  logic              execute_wren;
  logic [REG_AW-1:0] execute_waddr;
  logic              complete_valid;
  logic [REG_AW-1:0] complete_waddr;
  logic              flush;
  logic              stall;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;
  logic              busy;

  modport master (
    output issue_valid, issue_rden1, issue_raddr1, issue_rden2, issue_raddr2,
           issue_wren, issue_waddr, issue_long, execute_wren, execute_waddr,
           complete_valid, complete_waddr, flush,
    input  stall, fwd_sel1, fwd_sel2, busy
  );

  modport slave (
    input  issue_valid, issue_rden1, issue_raddr1, issue_rden2, issue_raddr2,
           issue_wren, issue_waddr, issue_long, execute_wren, execute_waddr,
           complete_valid, complete_waddr, flush,
    output stall, fwd_sel1, fwd_sel2, busy
  );

endinterface

// File: rtl/scoreboard_operand.sv
// Hazard and forwarding-source decision for one source operand.
module scoreboard_operand
  import scoreboard_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic              rden,
  input  logic [REG_AW-1:0] raddr,
  input  logic [NREG-1:0]   pending,
  input  logic              execute_wren,
  input  logic [REG_AW-1:0] execute_waddr,
  input  logic              complete_valid,
  input  logic [REG_AW-1:0] complete_waddr,
  output logic              hazard,
  output logic [1:0]        sel
);

  // A same-cycle completion outranks the pending bit it is about to clear.
  always_comb begin
    hazard = 1'b0;
    sel    = FWD_REG;
    if (rden && raddr != '0) begin
      if (complete_valid && complete_waddr == raddr) begin
        sel = FWD_CMP;
      end else if (pending[raddr]) begin
        hazard = 1'b1;
      end else if (execute_wren && execute_waddr == raddr) begin
        sel = FWD_EXE;
      end
    end
  end

endmodule

// File: rtl/scoreboard.sv
// Register-hazard scoreboard: pending-destination vector, long-op counter,
// issue stall and per-operand forwarding selects.
module scoreboard
  import scoreboard_pkg::*;
#(
  parameter int NREG   = 32,
  parameter int MAXOUT = 4    // 1..15, bounded by the 4-bit counter
) (
  input  logic       clock,
  input  logic       reset,
  scoreboard_if.slave sb
);

  localparam int              CW      = 4;
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAXOUT);

  scoreboard_in_type  sin;
  scoreboard_out_type sout;

  logic [NREG-1:0] pending, pending_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            hazard1, hazard2;
  logic [1:0]      sel1, sel2;
  logic            cmp_hit_w, waw, full, accept, set_pend;

  function automatic logic [CW-1:0] step_count(input logic [CW-1:0] c,
                                                input logic inc, input logic dec);
    if (dec && !inc && c == '0) return '0;
    return c + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
  endfunction

  always_comb begin
    sin.issue_valid    = sb.issue_valid;
    sin.issue_rden1    = sb.issue_rden1;
    sin.issue_raddr1   = sb.issue_raddr1;
    sin.issue_rden2    = sb.issue_rden2;
    sin.issue_raddr2   = sb.issue_raddr2;
    sin.issue_wren     = sb.issue_wren;
    sin.issue_waddr    = sb.issue_waddr;
    sin.issue_long     = sb.issue_long;
    sin.execute_wren   = sb.execute_wren;
    sin.execute_waddr  = sb.execute_waddr;
    sin.complete_valid = sb.complete_valid;
    sin.complete_waddr = sb.complete_waddr;
    sin.flush          = sb.flush;
  end

  scoreboard_operand #(.NREG(NREG)) u_op1 (
    .rden(sin.issue_rden1), .raddr(sin.issue_raddr1), .pending(pending),
    .execute_wren(sin.execute_wren), .execute_waddr(sin.execute_waddr),
    .complete_valid(sin.complete_valid), .complete_waddr(sin.complete_waddr),
    .hazard(hazard1), .sel(sel1)
  );

  scoreboard_operand #(.NREG(NREG)) u_op2 (
    .rden(sin.issue_rden2), .raddr(sin.issue_raddr2), .pending(pending),
    .execute_wren(sin.execute_wren), .execute_waddr(sin.execute_waddr),
    .complete_valid(sin.complete_valid), .complete_waddr(sin.complete_waddr),
    .hazard(hazard2), .sel(sel2)
  );

  // A completion frees its slot in the same cycle, so it lifts both WAW and full.
  assign cmp_hit_w = sin.complete_valid && sin.complete_waddr == sin.issue_waddr;
  assign waw       = sin.issue_wren && sin.issue_long && sin.issue_waddr != '0 &&
                     pending[sin.issue_waddr] && !cmp_hit_w;
  assign full      = sin.issue_long && count == MAX_CNT && !sin.complete_valid;

  assign sout.stall    = sin.issue_valid && !sin.flush &&
                         (hazard1 || hazard2 || waw || full);
  assign sout.fwd_sel1 = sel1;
  assign sout.fwd_sel2 = sel2;
  assign sout.busy     = count != '0;

  assign accept   = sin.issue_valid && !sout.stall && !sin.flush;
  assign set_pend = accept && sin.issue_long && sin.issue_wren && sin.issue_waddr != '0;

  always_comb begin
    pending_nxt = pending;
    count_nxt   = count;
    if (sin.flush) begin
      pending_nxt = '0;
      count_nxt   = '0;
    end else begin
      if (sin.complete_valid) pending_nxt[sin.complete_waddr] = 1'b0;
      if (set_pend)           pending_nxt[sin.issue_waddr]    = 1'b1;
      pending_nxt[0] = 1'b0;
      count_nxt = step_count(count, accept && sin.issue_long, sin.complete_valid);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_nxt;
      count   <= count_nxt;
    end
  end

  assign sb.stall    = sout.stall;
  assign sb.fwd_sel1 = sout.fwd_sel1;
  assign sb.fwd_sel2 = sout.fwd_sel2;
  assign sb.busy     = sout.busy;

  // Completing with nothing outstanding is a pipeline bug upstream.
  property no_underflow;
    @(posedge clock) disable iff (!reset)
      !(sin.complete_valid && !sin.flush && count == '0);
  endproperty
  assert property (no_underflow);

endmodule

// File: tb/tb_scoreboard.sv
// Directed and randomized bench for scoreboard against a behavioural model.
module tb_scoreboard;
  import scoreboard_pkg::*;

  localparam int MAXOUT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;

  scoreboard_if sb();

  scoreboard #(.NREG(32), .MAXOUT(MAXOUT)) dut (
    .clock(clock),
    .reset(reset),
    .sb(sb)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: which registers await a long-op result, and how many long ops are in flight.
  bit pend_m[32];
  int cnt_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = pend_m[i];
    return v;
  endfunction

  function automatic void op_model(input logic rden, input logic [4:0] ra,
                                   output logic hz, output logic [1:0] sel);
    hz  = 1'b0;
    sel = 2'b00;
    if (rden && ra != 5'd0) begin
      if (sb.complete_valid && sb.complete_waddr == ra) sel = 2'b10;
      else if (pend_m[ra]) hz = 1'b1;
      else if (sb.execute_wren && sb.execute_waddr == ra) sel = 2'b01;
    end
  endfunction

  task automatic drive(input logic v, input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2,
                       input logic w, input logic [4:0] wa, input logic lg,
                       input logic ew, input logic [4:0] ea,
                       input logic cv, input logic [4:0] ca, input logic fl);
    sb.issue_valid    = v;
    sb.issue_rden1    = r1;
    sb.issue_raddr1   = a1;
    sb.issue_rden2    = r2;
    sb.issue_raddr2   = a2;
    sb.issue_wren     = w;
    sb.issue_waddr    = wa;
    sb.issue_long     = lg;
    sb.execute_wren   = ew;
    sb.execute_waddr  = ea;
    sb.complete_valid = cv;
    sb.complete_waddr = ca;
    sb.flush          = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic long_op(input logic [4:0] wa);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, wa, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic complete(input logic [4:0] ca);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, ca, 1'b0);
  endtask

  // Check combinational outputs for the inputs now applied, clock once, then check state.
  task automatic tick();
    logic h1, h2, waw, full, acc, e_stall;
    logic [1:0] e_sel1, e_sel2;
    op_model(sb.issue_rden1, sb.issue_raddr1, h1, e_sel1);
    op_model(sb.issue_rden2, sb.issue_raddr2, h2, e_sel2);
    waw = sb.issue_wren && sb.issue_long && sb.issue_waddr != 5'd0 && pend_m[sb.issue_waddr] &&
          !(sb.complete_valid && sb.complete_waddr == sb.issue_waddr);
    full = sb.issue_long && cnt_m == MAXOUT && !sb.complete_valid;
    e_stall = sb.issue_valid && !sb.flush && (h1 || h2 || waw || full);
    acc = sb.issue_valid && !e_stall && !sb.flush;
    check("stall", 32'(sb.stall), 32'(e_stall));
    check("sel1", 32'(sb.fwd_sel1), 32'(e_sel1));
    check("sel2", 32'(sb.fwd_sel2), 32'(e_sel2));
    check("busy", 32'(sb.busy), 32'(cnt_m != 0));
    if (sb.flush) begin
      for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
      cnt_m = 0;
    end else begin
      if (sb.complete_valid) pend_m[sb.complete_waddr] = 1'b0;
      if (acc && sb.issue_long && sb.issue_wren && sb.issue_waddr != 5'd0)
        pend_m[sb.issue_waddr] = 1'b1;
      cnt_m = cnt_m + int'(acc && sb.issue_long) - int'(sb.complete_valid);
      if (cnt_m < 0) cnt_m = 0;
    end
    @(posedge clock);
    @(negedge clock);
    check("pending", 32'(dut.pending), pend_vec());
    check("count", 32'(dut.count), 32'(cnt_m));
  endtask

  initial begin
    logic [4:0] regs [$];
    logic v, r1, r2, w, lg, ew, cv, fl;
    logic [4:0] a1, a2, wa, ea, ca;

    idle();
    check("rst_stall", 32'(sb.stall), 32'd0);
    check("rst_sel1", 32'(sb.fwd_sel1), 32'd0);
    check("rst_sel2", 32'(sb.fwd_sel2), 32'd0);
    check("rst_busy", 32'(sb.busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // add x3 <- x1, x2 with nothing in flight
    drive(1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    check("add_stall", 32'(sb.stall), 32'd0);
    check("add_sel1", 32'(sb.fwd_sel1), 32'd0);
    tick();

    // load x5, then a reader of x5 waits for its completion
    long_op(5'd5);
    check("ld5_stall", 32'(sb.stall), 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      check("raw5_stall", 32'(sb.stall), 32'd1);
      tick();
    end
    drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    check("cmp5_stall", 32'(sb.stall), 32'd0);
    check("cmp5_sel1", 32'(sb.fwd_sel1), 32'd2);
    tick();
    check("x5_clear", 32'(dut.pending[5]), 32'd0);
    check("x5_busy", 32'(sb.busy), 32'd0);

    // execute forwarding, and x0 never forwards
    drive(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
    check("exe_sel1", 32'(sb.fwd_sel1), 32'd1);
    check("exe_stall", 32'(sb.stall), 32'd0);
    tick();
    drive(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    check("x0_sel1", 32'(sb.fwd_sel1), 32'd0);
    tick();

    // fill MAXOUT long ops, then a fifth
    for (int i = 1; i <= 4; i++) begin
      long_op(5'(i));
      tick();
    end
    long_op(5'd8);
    check("full_stall", 32'(sb.stall), 32'd1);
    check("full_busy", 32'(sb.busy), 32'd1);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 1'b0);
    check("full_cmp_stall", 32'(sb.stall), 32'd0);
    tick();
    check("full_count", 32'(dut.count), 32'd4);
    complete(5'd2); tick();
    complete(5'd3); tick();
    complete(5'd4); tick();
    complete(5'd8); tick();

    // complete x6 and reissue a long op to x6 in the same cycle
    long_op(5'd6);
    tick();
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0);
    check("waw6_stall", 32'(sb.stall), 32'd0);
    tick();
    check("waw6_pend", 32'(dut.pending[6]), 32'd1);
    check("waw6_count", 32'(dut.count), 32'd1);

    // flush with three loads in flight
    long_op(5'd10); tick();
    long_op(5'd11); tick();
    drive(1'b1, 1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    check("flush_stall", 32'(sb.stall), 32'd0);
    tick();
    check("flush_busy", 32'(sb.busy), 32'd0);
    check("flush_pend", 32'(dut.pending), 32'd0);

    // asynchronous reset in the middle of activity
    long_op(5'd12); tick();
    long_op(5'd13); tick();
    idle();
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(sb.busy), 32'd0);
    check("arst_pend", 32'(dut.pending), 32'd0);
    check("arst_count", 32'(dut.count), 32'd0);
    for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
    cnt_m = 0;
    @(negedge clock);
    reset = 1'b1;

    // randomized traffic over a small register window to provoke hazards
    repeat (1500) begin
      v  = ($urandom_range(0, 9) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      r2 = ($urandom_range(0, 3) != 0);
      a1 = 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, 7));
      w  = ($urandom_range(0, 4) != 0);
      wa = 5'($urandom_range(0, 7));
      lg = ($urandom_range(0, 2) == 0);
      ew = ($urandom_range(0, 1) == 0);
      ea = 5'($urandom_range(0, 7));
      fl = ($urandom_range(0, 39) == 0);
      cv = (cnt_m > 0) && ($urandom_range(0, 2) == 0);
      regs.delete();
      for (int i = 1; i < 32; i++) if (pend_m[i]) regs.push_back(5'(i));
      if (regs.size() != 0) ca = regs[$urandom_range(0, regs.size() - 1)];
      else ca = 5'($urandom_range(1, 7));
      drive(v, r1, a1, r2, a2, w, wa, lg, ew, ea, cv, ca, fl);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
